// File: rtl/graphic_layer_table_if.sv
// Bus bundle for graphic_layer_table.
// master: host / scan side (drives writes, commit control and scan coordinates).
// slave : the layer table (drives commit status and composited pixel outputs).
interface graphic_layer_table_if #(
  parameter int ENTRIES = 64,
  parameter int ADDR_W  = $clog2(ENTRIES),
  parameter int COORD_W = 10,
  parameter int COLOR_W = 16
);
  logic               WRITE;
  logic [ADDR_W-1:0]  WRITE_ADDRESS;
  logic [1:0]         WORD_SEL;
  logic [31:0]        INSTRUCTION;
  logic               CLEAR;
  logic               COMMIT;
  logic               FRAME_SYNC;
  logic [COORD_W-1:0] SYS_X;
  logic [COORD_W-1:0] SYS_Y;
  logic               COMMIT_PENDING;
  logic               COMMIT_DONE;
  logic [COLOR_W-1:0] CURRENT_GRAPHIC_DATA;
  logic               HIT;
  logic [ADDR_W-1:0]  HIT_INDEX;

  modport master (
    output WRITE, WRITE_ADDRESS, WORD_SEL, INSTRUCTION, CLEAR, COMMIT, FRAME_SYNC,
           SYS_X, SYS_Y,
    input  COMMIT_PENDING, COMMIT_DONE, CURRENT_GRAPHIC_DATA, HIT, HIT_INDEX
  );

  modport slave (
    input  WRITE, WRITE_ADDRESS, WORD_SEL, INSTRUCTION, CLEAR, COMMIT, FRAME_SYNC,
           SYS_X, SYS_Y,
    output COMMIT_PENDING, COMMIT_DONE, CURRENT_GRAPHIC_DATA, HIT, HIT_INDEX
  );
endinterface

// File: rtl/graphic_layer_table.sv
// Double-buffered rectangle layer table with a 2-stage compositing pipeline.
// Ports:
//   CLK, RST   clock and asynchronous active-high reset
//   bus        graphic_layer_table_if.slave:
//              WRITE/WRITE_ADDRESS/WORD_SEL/INSTRUCTION  shadow field writes
//              CLEAR                                     clear all shadow enables
//              COMMIT/FRAME_SYNC                         shadow-to-active copy control
//              SYS_X/SYS_Y                               scan coordinate
//              COMMIT_PENDING/COMMIT_DONE                commit status
//              CURRENT_GRAPHIC_DATA/HIT/HIT_INDEX        composited result (2-cycle latency)
module graphic_layer_table #(
  parameter int               ENTRIES  = 64,
  parameter int               ADDR_W   = $clog2(ENTRIES),
  parameter int               COORD_W  = 10,
  parameter int               COLOR_W  = 16,
  parameter logic [COLOR_W-1:0] BG_COLOR = 16'hFFFF
) (
  input logic                  CLK,
  input logic                  RST,
  graphic_layer_table_if.slave bus
);

  localparam logic [ADDR_W:0] ENTRIES_L = (ADDR_W+1)'(ENTRIES);

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_PENDING = 1'b1} state_e;

  state_e             state_r;
  logic               commit_pending_r;
  logic               commit_done_r;
  logic               copy_s;
  logic               wr_ok_s;
  logic [COORD_W-1:0] wr_lo_s;
  logic [COORD_W-1:0] wr_hi_s;
  logic               unused_instr_s;

  logic [COORD_W-1:0] sh_x0_r [ENTRIES];
  logic [COORD_W-1:0] sh_x1_r [ENTRIES];
  logic [COORD_W-1:0] sh_y0_r [ENTRIES];
  logic [COORD_W-1:0] sh_y1_r [ENTRIES];
  logic [COLOR_W-1:0] sh_col_r[ENTRIES];
  logic [ENTRIES-1:0] sh_en_r;

  logic [COORD_W-1:0] act_x0_r [ENTRIES];
  logic [COORD_W-1:0] act_x1_r [ENTRIES];
  logic [COORD_W-1:0] act_y0_r [ENTRIES];
  logic [COORD_W-1:0] act_y1_r [ENTRIES];
  logic [COLOR_W-1:0] act_col_r[ENTRIES];
  logic [ENTRIES-1:0] act_en_r;

  logic [ENTRIES-1:0] hit_s1_s;
  logic [ENTRIES-1:0] hit_vec_r;
  logic [COLOR_W-1:0] col_s1_r[ENTRIES];

  logic               hit_s2_s;
  logic [ADDR_W-1:0]  idx_s2_s;
  logic [COLOR_W-1:0] col_s2_s;
  logic               hit_r;
  logic [ADDR_W-1:0]  idx_r;
  logic [COLOR_W-1:0] col_r;

  // Out-of-range addresses and the reserved field select are dropped here.
  assign wr_ok_s = bus.WRITE && ({1'b0, bus.WRITE_ADDRESS} < ENTRIES_L) && (bus.WORD_SEL != 2'd3);
  assign wr_lo_s = bus.INSTRUCTION[COORD_W-1:0];
  assign wr_hi_s = bus.INSTRUCTION[16+COORD_W-1:16];
  assign unused_instr_s = ^bus.INSTRUCTION;

  // Copy strobe: FRAME_SYNC while pending, or COMMIT and FRAME_SYNC together while idle.
  always_comb begin
    copy_s = 1'b0;
    case (state_r)
      ST_IDLE:    copy_s = bus.COMMIT & bus.FRAME_SYNC;
      ST_PENDING: copy_s = bus.FRAME_SYNC;
      default:    copy_s = 1'b0;
    endcase
  end

  // Commit FSM with registered status outputs.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_r          <= ST_IDLE;
      commit_pending_r <= 1'b0;
      commit_done_r    <= 1'b0;
    end else begin
      commit_done_r <= copy_s;
      case (state_r)
        ST_IDLE: begin
          if (bus.COMMIT && !bus.FRAME_SYNC) begin
            state_r          <= ST_PENDING;
            commit_pending_r <= 1'b1;
          end else begin
            state_r          <= ST_IDLE;
            commit_pending_r <= 1'b0;
          end
        end
        ST_PENDING: begin
          if (bus.FRAME_SYNC) begin
            state_r          <= ST_IDLE;
            commit_pending_r <= 1'b0;
          end else begin
            state_r          <= ST_PENDING;
            commit_pending_r <= 1'b1;
          end
        end
        default: begin
          state_r          <= ST_IDLE;
          commit_pending_r <= 1'b0;
        end
      endcase
    end
  end

  // Shadow table: CLEAR first, then the addressed write, so a colour/enable write beats CLEAR.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < ENTRIES; i++) begin
        sh_x0_r[i]  <= '0;
        sh_x1_r[i]  <= '0;
        sh_y0_r[i]  <= '0;
        sh_y1_r[i]  <= '0;
        sh_col_r[i] <= '0;
      end
      sh_en_r <= '0;
    end else begin
      if (bus.CLEAR) begin
        sh_en_r <= '0;
      end
      for (int i = 0; i < ENTRIES; i++) begin
        if (wr_ok_s && (bus.WRITE_ADDRESS == ADDR_W'(i))) begin
          case (bus.WORD_SEL)
            2'd0: begin
              sh_x0_r[i] <= wr_lo_s;
              sh_x1_r[i] <= wr_hi_s;
            end
            2'd1: begin
              sh_y0_r[i] <= wr_lo_s;
              sh_y1_r[i] <= wr_hi_s;
            end
            2'd2: begin
              sh_col_r[i] <= bus.INSTRUCTION[COLOR_W-1:0];
              sh_en_r[i]  <= bus.INSTRUCTION[31];
            end
            default: begin
            end
          endcase
        end
      end
    end
  end

  // Active table takes the pre-edge shadow contents on a copy.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < ENTRIES; i++) begin
        act_x0_r[i]  <= '0;
        act_x1_r[i]  <= '0;
        act_y0_r[i]  <= '0;
        act_y1_r[i]  <= '0;
        act_col_r[i] <= '0;
      end
      act_en_r <= '0;
    end else if (copy_s) begin
      for (int i = 0; i < ENTRIES; i++) begin
        act_x0_r[i]  <= sh_x0_r[i];
        act_x1_r[i]  <= sh_x1_r[i];
        act_y0_r[i]  <= sh_y0_r[i];
        act_y1_r[i]  <= sh_y1_r[i];
        act_col_r[i] <= sh_col_r[i];
      end
      act_en_r <= sh_en_r;
    end
  end

  // Per-entry inclusive range test; an inverted range can never satisfy both bounds.
  always_comb begin
    hit_s1_s = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      hit_s1_s[i] = act_en_r[i] &&
                    (act_x0_r[i] <= bus.SYS_X) && (bus.SYS_X <= act_x1_r[i]) &&
                    (act_y0_r[i] <= bus.SYS_Y) && (bus.SYS_Y <= act_y1_r[i]);
    end
  end

  // Stage 1: hit vector plus colours, so in-flight pixels keep the colour seen here.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      hit_vec_r <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        col_s1_r[i] <= '0;
      end
    end else begin
      hit_vec_r <= hit_s1_s;
      for (int i = 0; i < ENTRIES; i++) begin
        col_s1_r[i] <= act_col_r[i];
      end
    end
  end

  // Highest set index wins: ascending scan, later hits overwrite earlier ones.
  always_comb begin
    hit_s2_s = 1'b0;
    idx_s2_s = '0;
    col_s2_s = BG_COLOR;
    for (int i = 0; i < ENTRIES; i++) begin
      hit_s2_s = hit_s2_s | hit_vec_r[i];
      idx_s2_s = hit_vec_r[i] ? ADDR_W'(i) : idx_s2_s;
      col_s2_s = hit_vec_r[i] ? col_s1_r[i] : col_s2_s;
    end
  end

  // Stage 2: registered pixel outputs.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      hit_r <= 1'b0;
      idx_r <= '0;
      col_r <= BG_COLOR;
    end else begin
      hit_r <= hit_s2_s;
      idx_r <= idx_s2_s;
      col_r <= col_s2_s;
    end
  end

  assign bus.COMMIT_PENDING       = commit_pending_r;
  assign bus.COMMIT_DONE          = commit_done_r;
  assign bus.CURRENT_GRAPHIC_DATA = col_r;
  assign bus.HIT                  = hit_r;
  assign bus.HIT_INDEX            = idx_r;

endmodule

// File: tb/tb_graphic_layer_table.sv
// Directed self-checking bench for graphic_layer_table (12 entries so that
// an out-of-range write address is representable).
module tb_graphic_layer_table;

  localparam int ENTRIES = 12;
  localparam int ADDR_W  = $clog2(ENTRIES);
  localparam int COORD_W = 10;
  localparam int COLOR_W = 16;
  localparam logic [15:0] BG = 16'hFFFF;

  logic CLK;
  logic RST;
  int   checks_cnt;
  int   errors_cnt;

  graphic_layer_table_if #(.ENTRIES(ENTRIES), .ADDR_W(ADDR_W), .COORD_W(COORD_W), .COLOR_W(COLOR_W)) bus ();

  graphic_layer_table #(
    .ENTRIES(ENTRIES), .ADDR_W(ADDR_W), .COORD_W(COORD_W), .COLOR_W(COLOR_W), .BG_COLOR(BG)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_cnt++;
    if (obs !== exp) begin
      errors_cnt++;
      $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [31:0] rng(input int lo, input int hi);
    logic [31:0] v;
    v = '0;
    v[9:0]   = 10'(lo);
    v[25:16] = 10'(hi);
    return v;
  endfunction

  task automatic wr(input int addr, input int sel, input logic [31:0] data, input logic clr);
    bus.WRITE         = 1'b1;
    bus.WRITE_ADDRESS = ADDR_W'(addr);
    bus.WORD_SEL      = 2'(sel);
    bus.INSTRUCTION   = data;
    bus.CLEAR         = clr;
    tick();
    bus.WRITE = 1'b0;
    bus.CLEAR = 1'b0;
  endtask

  task automatic commit_now(input string tag);
    bus.COMMIT     = 1'b1;
    bus.FRAME_SYNC = 1'b1;
    tick();
    bus.COMMIT     = 1'b0;
    bus.FRAME_SYNC = 1'b0;
    check({tag, "_done"}, {31'd0, bus.COMMIT_DONE}, 32'd1);
    check({tag, "_pend"}, {31'd0, bus.COMMIT_PENDING}, 32'd0);
  endtask

  task automatic pix(input string tag, input int x, input int y,
                     input logic [15:0] col, input logic h, input int idx);
    bus.SYS_X = COORD_W'(x);
    bus.SYS_Y = COORD_W'(y);
    tick();
    tick();
    check({tag, "_col"}, {16'd0, bus.CURRENT_GRAPHIC_DATA}, {16'd0, col});
    check({tag, "_hit"}, {31'd0, bus.HIT}, {31'd0, h});
    check({tag, "_idx"}, {28'd0, bus.HIT_INDEX}, 32'(idx));
  endtask

  initial begin
    checks_cnt = 0;
    errors_cnt = 0;
    RST = 1'b1;
    bus.WRITE = 1'b0; bus.WRITE_ADDRESS = '0; bus.WORD_SEL = 2'd0; bus.INSTRUCTION = 32'd0;
    bus.CLEAR = 1'b0; bus.COMMIT = 1'b0; bus.FRAME_SYNC = 1'b0;
    bus.SYS_X = '0; bus.SYS_Y = '0;
    tick();
    tick();
    check("rst_pend", {31'd0, bus.COMMIT_PENDING}, 32'd0);
    check("rst_done", {31'd0, bus.COMMIT_DONE}, 32'd0);
    check("rst_col",  {16'd0, bus.CURRENT_GRAPHIC_DATA}, {16'd0, BG});
    check("rst_hit",  {31'd0, bus.HIT}, 32'd0);
    check("rst_idx",  {28'd0, bus.HIT_INDEX}, 32'd0);
    RST = 1'b0;

    // Pipelined sweep (0,0)..(3,3): one pixel per cycle, each checked 2 cycles later.
    for (int n = 0; n <= 16; n++) begin
      if (n < 16) begin
        bus.SYS_X = COORD_W'(n % 4);
        bus.SYS_Y = COORD_W'(n / 4);
      end
      tick();
      if (n >= 1) begin
        check("sweep_col", {16'd0, bus.CURRENT_GRAPHIC_DATA}, {16'd0, BG});
        check("sweep_hit", {31'd0, bus.HIT}, 32'd0);
      end
    end
    check("sweep_pend", {31'd0, bus.COMMIT_PENDING}, 32'd0);

    // Entry 5 and a deferred commit.
    wr(5, 0, rng(10, 20), 1'b0);
    wr(5, 1, rng(10, 20), 1'b0);
    wr(5, 2, 32'h8000_07E0, 1'b0);
    bus.COMMIT = 1'b1;
    tick();
    bus.COMMIT = 1'b0;
    check("pend_c1", {31'd0, bus.COMMIT_PENDING}, 32'd1);
    tick();
    check("pend_c2", {31'd0, bus.COMMIT_PENDING}, 32'd1);
    bus.COMMIT = 1'b1;                       // absorbed while pending
    tick();
    bus.COMMIT = 1'b0;
    check("pend_c3", {31'd0, bus.COMMIT_PENDING}, 32'd1);
    check("pend_nodone", {31'd0, bus.COMMIT_DONE}, 32'd0);
    bus.FRAME_SYNC = 1'b1;
    tick();
    bus.FRAME_SYNC = 1'b0;
    check("fs_pend", {31'd0, bus.COMMIT_PENDING}, 32'd0);
    check("fs_done", {31'd0, bus.COMMIT_DONE}, 32'd1);
    tick();
    check("done_pulse", {31'd0, bus.COMMIT_DONE}, 32'd0);
    bus.FRAME_SYNC = 1'b1;                   // idle frame sync does nothing
    tick();
    bus.FRAME_SYNC = 1'b0;
    check("idle_fs_pend", {31'd0, bus.COMMIT_PENDING}, 32'd0);
    tick();
    check("idle_fs_done", {31'd0, bus.COMMIT_DONE}, 32'd0);

    pix("p15_15", 15, 15, 16'h07E0, 1'b1, 5);
    pix("p10_10", 10, 10, 16'h07E0, 1'b1, 5);
    pix("p20_20", 20, 20, 16'h07E0, 1'b1, 5);
    pix("p9_15",   9, 15, BG, 1'b0, 0);
    pix("p21_15", 21, 15, BG, 1'b0, 0);

    // Entry 9 overlaps entry 5 and wins where both hit.
    wr(9, 0, rng(15, 30), 1'b0);
    wr(9, 1, rng(15, 30), 1'b0);
    wr(9, 2, 32'h8000_F800, 1'b0);
    commit_now("c9");
    pix("p16_16", 16, 16, 16'hF800, 1'b1, 9);
    pix("p12_12", 12, 12, 16'h07E0, 1'b1, 5);

    // Shadow-only colour change is invisible until committed.
    wr(9, 2, 32'h8000_001F, 1'b0);
    pix("shadow_only", 16, 16, 16'hF800, 1'b1, 9);
    commit_now("c9b");
    // Back-to-back pixels through the pipeline.
    bus.SYS_X = 10'd16; bus.SYS_Y = 10'd16;
    tick();
    bus.SYS_X = 10'd12; bus.SYS_Y = 10'd12;
    tick();
    check("tp0_col", {16'd0, bus.CURRENT_GRAPHIC_DATA}, 32'h001F);
    bus.SYS_X = 10'd0; bus.SYS_Y = 10'd0;
    tick();
    check("tp1_col", {16'd0, bus.CURRENT_GRAPHIC_DATA}, 32'h07E0);
    check("tp1_idx", {28'd0, bus.HIT_INDEX}, 32'd5);
    tick();
    check("tp2_col", {16'd0, bus.CURRENT_GRAPHIC_DATA}, {16'd0, BG});
    check("tp2_hit", {31'd0, bus.HIT}, 32'd0);

    // CLEAR in the copy cycle only touches the shadow.
    bus.CLEAR = 1'b1;
    commit_now("cclr");
    bus.CLEAR = 1'b0;
    pix("clr_keep9", 16, 16, 16'h001F, 1'b1, 9);
    pix("clr_keep5", 12, 12, 16'h07E0, 1'b1, 5);
    commit_now("cclr2");
    pix("clr_bg16", 16, 16, BG, 1'b0, 0);
    pix("clr_bg12", 12, 12, BG, 1'b0, 0);

    // Reserved field select is ignored.
    wr(5, 3, 32'h8000_ABCD, 1'b0);
    commit_now("csel3");
    pix("sel3_nohit", 15, 15, BG, 1'b0, 0);

    // Enable write coinciding with CLEAR keeps that entry enabled.
    wr(5, 2, 32'h8000_07E0, 1'b1);
    commit_now("cwc");
    pix("wc_5", 15, 15, 16'h07E0, 1'b1, 5);
    pix("wc_9off", 25, 25, BG, 1'b0, 0);

    // Inverted X range never hits.
    wr(3, 0, rng(30, 20), 1'b0);
    wr(3, 1, rng(0, 40), 1'b0);
    wr(3, 2, 32'h8000_1111, 1'b0);
    commit_now("cinv");
    pix("inv_25", 25, 5, BG, 1'b0, 0);
    pix("inv_20", 20, 5, BG, 1'b0, 0);
    pix("inv_30", 30, 5, BG, 1'b0, 0);

    // Write to address ENTRIES changes nothing.
    wr(ENTRIES, 0, rng(0, 1023), 1'b0);
    wr(ENTRIES, 1, rng(0, 1023), 1'b0);
    wr(ENTRIES, 2, 32'h8000_2222, 1'b0);
    commit_now("coor");
    pix("oor_0", 0, 0, BG, 1'b0, 0);
    pix("oor_5", 15, 15, 16'h07E0, 1'b1, 5);

    // Asynchronous reset while pending.
    bus.COMMIT = 1'b1;
    tick();
    bus.COMMIT = 1'b0;
    check("arst_pre_pend", {31'd0, bus.COMMIT_PENDING}, 32'd1);
    check("arst_pre_col", {16'd0, bus.CURRENT_GRAPHIC_DATA}, 32'h07E0);
    #2;
    RST = 1'b1;
    #1;
    check("arst_pend", {31'd0, bus.COMMIT_PENDING}, 32'd0);
    check("arst_col", {16'd0, bus.CURRENT_GRAPHIC_DATA}, {16'd0, BG});
    check("arst_hit", {31'd0, bus.HIT}, 32'd0);
    check("arst_idx", {28'd0, bus.HIT_INDEX}, 32'd0);
    tick();
    RST = 1'b0;
    pix("post_rst", 15, 15, BG, 1'b0, 0);

    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end

endmodule

// File: doc/graphic_layer_table.md
Name: graphic_layer_table

Overview:
- Parametrised successor to the fixed 64-entry graphic register chain in the GPU.
- Holds ENTRIES rectangle descriptors, each with an inclusive X/Y range, a colour and an enable bit.
- For each scan coordinate it outputs the colour of the highest-index enabled rectangle containing it, else BG_COLOR, through a 2-stage pipeline.
- Adds shadow/active double buffering with frame-synchronised commit, a one-cycle global clear, and hit/index reporting.

Parameters:
ENTRIES, 64, number of descriptors (2..256)
ADDR_W, $clog2(ENTRIES), write address width
COORD_W, 10, coordinate width (1..16)
COLOR_W, 16, colour width (1..31)
BG_COLOR, 16'hFFFF, colour output when no entry hits (COLOR_W bits)

Ports:
CLK  in  1  clock
RST  in  1  asynchronous active-high reset
WRITE  in  1  write strobe for the shadow table
WRITE_ADDRESS  in  ADDR_W  entry index
WORD_SEL  in  2  field select: 0 = X range, 1 = Y range, 2 = colour/enable, 3 = reserved
INSTRUCTION  in  32  write data
CLEAR  in  1  pulse: clear all shadow enables
COMMIT  in  1  pulse: request shadow-to-active copy
FRAME_SYNC  in  1  pulse at frame start (vertical blank)
SYS_X, SYS_Y  in  COORD_W  current scan coordinate
COMMIT_PENDING  out  1  a commit request is waiting for FRAME_SYNC
COMMIT_DONE  out  1  one-cycle pulse when the copy occurs
CURRENT_GRAPHIC_DATA  out  COLOR_W  composited pixel colour
HIT  out  1  some enabled entry covers the pixel
HIT_INDEX  out  ADDR_W  winning entry index (0 when HIT=0)

Behaviour:
- Reset is asynchronous. It clears all shadow and active fields, sets enables to 0, COMMIT_PENDING=0, COMMIT_DONE=0, HIT=0, HIT_INDEX=0, CURRENT_GRAPHIC_DATA=BG_COLOR, and flushes the pipeline.
- Field layout:
  - WORD_SEL 0: X0=INSTRUCTION[COORD_W-1:0], X1=INSTRUCTION[16+COORD_W-1:16].
  - WORD_SEL 1: Y0 and Y1, same bit positions.
  - WORD_SEL 2: colour=INSTRUCTION[COLOR_W-1:0], enable=INSTRUCTION[31].
- Writes update only the addressed shadow field at the clock edge. They are ignored if WRITE_ADDRESS>=ENTRIES or WORD_SEL=3.
- CLEAR zeroes every shadow enable in one cycle; other shadow fields are kept. If WRITE with WORD_SEL 2 coincides with CLEAR, the write's enable wins for that entry.
- Commit FSM, states IDLE and PENDING:
  - IDLE to PENDING on COMMIT.
  - PENDING to IDLE on FRAME_SYNC: the full shadow table is copied into the active table and COMMIT_DONE pulses 1 cycle.
  - COMMIT and FRAME_SYNC in the same cycle while IDLE: the copy happens that cycle, with COMMIT_DONE=1 and no PENDING state.
  - COMMIT while already PENDING is absorbed.
  - FRAME_SYNC while IDLE does nothing.
  - COMMIT_PENDING=1 exactly in PENDING.
- Copy-cycle collisions: a write or CLEAR in the copy cycle affects the shadow only. The active table receives the pre-edge shadow values.
- Hit test: entry i hits when it is active-enabled and X0<=SYS_X<=X1 and Y0<=SYS_Y<=Y1 (unsigned, inclusive). X0>X1 or Y0>Y1 never hits.
- Pipeline:
  - Stage 1 registers the ENTRIES-bit hit vector plus active colours.
  - Stage 2 selects the highest set index and registers CURRENT_GRAPHIC_DATA, HIT and HIT_INDEX.
  - Latency is exactly 2 cycles from SYS_X/SYS_Y to outputs, with throughput 1 pixel/cycle.
- An active-table change (copy) is visible on outputs 2 cycles after the copy edge. Pixels already in the pipeline use the colour captured in stage 1.
- Priority: highest index wins, matching the existing chain ordering. No hit gives BG_COLOR, HIT=0, HIT_INDEX=0.

Test Plan:
- Reset, then sweep (0,0)..(3,3) -> CURRENT_GRAPHIC_DATA=16'hFFFF, HIT=0 for every pixel; COMMIT_PENDING=0.
- Write entry 5: X 10..20, Y 10..20, colour 16'h07E0, enable=1. Then COMMIT, then FRAME_SYNC 3 cycles later -> COMMIT_PENDING high for 3 cycles, COMMIT_DONE pulse. Pixel (15,15) gives 16'h07E0, HIT_INDEX=5, 2 cycles after it is presented. Pixels (9,15) and (21,15) give 16'hFFFF.
- Also enable entry 9 over X 15..30, Y 15..30 with colour 16'hF800, then commit -> (16,16) gives 16'hF800, HIT_INDEX=9; (12,12) gives 16'h07E0, HIT_INDEX=5.
- Write new colour 16'h001F to entry 9 without COMMIT -> output stays 16'hF800. After COMMIT plus FRAME_SYNC it becomes 16'h001F.
- CLEAR, COMMIT and FRAME_SYNC in the same cycle -> COMMIT_DONE=1, and active still shows the entries (pre-clear shadow). A second COMMIT plus FRAME_SYNC gives 16'hFFFF everywhere.
- Entry with X0=30, X1=20 enabled -> never hits. Write to WRITE_ADDRESS=ENTRIES (when ENTRIES<2^ADDR_W) -> no state change. Assert RST while PENDING -> COMMIT_PENDING=0 and outputs return to BG_COLOR immediately, asynchronously.
